aes128_iter_core: RTL and testbench
===================================

// Module: aes128_iter_core
// PURPOSE
//  Full AES-128 encryption engine: accepts one plaintext/key pair and runs all 10 rounds internally.
//  SubBytes and SubWord share SBOX_LANES S-box instances, so area/latency scale with one parameter.
//  Valid/ready handshakes on input and output; sits between the host block buffer and the cipher output.
//  Bytes use FIPS-197 order (byte 0 = bits [127:120]); key schedule per FIPS-197; Rcon generated in-core (xtime).
// PARAMETERS
//  SBOX_LANES  1  S-box instances; legal 1,2,4,8,16; any other value -> elaboration error (generate $error)
// PORTS
//  clock        in   1    rising-edge clock; single clock domain
//  reset        in   1    synchronous, active-high reset
//  in_valid     in   1    in_text/in_key valid
//  in_ready     out  1    core can accept a block (IDLE only)
//  in_text      in   128  plaintext
//  in_key       in   128  cipher key
//  out_valid    out  1    out_text holds a finished ciphertext
//  out_ready    in   1    consumer takes out_text
//  out_text     out  128  ciphertext
//  busy         out  1    high in every state except IDLE
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, round=0, rcon=8'h01, state/key regs=0, out_text=0, out_valid=0, busy=0, in_ready=1 after release.
//  Reset mid-operation aborts the block; no output produced; no partial result retained.
//  FSM: IDLE -> INIT -> SUB -> KEY -> MIX -> (SUB | DONE) -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready: latch in_text,in_key; go INIT. Inputs ignored after acceptance.
//  INIT (1 cyc): st <= text ^ key; round <= 1; rcon <= 01.
//  SUB (16/L cyc): each cycle L consecutive bytes of st replaced by S(byte), byte 0 first.
//  KEY (max(4/L,1) cyc): SubWord(RotWord(w3)) through lanes 0..min(L,4)-1; lanes reused, no dedicated S-box.
//  MIX (1 cyc): st <= MixColumns(ShiftRows(st)) ^ rk_next; MixColumns bypassed when round==10.
//   rk_next = FIPS-197 expansion of current rk with rcon; rk <= rk_next; rcon <= xtime(rcon); round++.
//   round<10 -> SUB; round==10 -> DONE, out_text <= result, out_valid <= 1.
//  DONE: out_valid and out_text held stable until out_ready; out_valid&out_ready -> IDLE, out_valid <= 0.
//   No same-cycle re-accept: in_ready rises the cycle after the output handshake.
//  out_text keeps last ciphertext after handshake until next block completes or reset.
//  Latency (accept edge -> out_valid high) = 1 + 10*(16/L + max(4/L,1) + 1) + 1 cycles:
//   L=1:212, L=2:112, L=4:62, L=8:42, L=16:32.
//  Throughput: one block per latency+1 cycles with out_ready held high.
//  in_valid while busy: ignored (in_ready=0); host must hold in_valid until accepted.
//  xtime: {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00); rcon sequence 01,02,04,08,10,20,40,80,1b,36.
// CONFIGURATION
//  AES_ROUND_TAP_EN defined: extra ports round_valid(out,1), round_idx(out,4), round_state(out,128).
//   round_valid pulses 1 cycle after each MIX, round_idx=1..10, round_state=st after AddRoundKey; all 0 at reset.
//  AES_ROUND_TAP_EN undefined: ports and logic absent; remaining behaviour identical.
// TESTING
//  T1 FIPS-197 C.1, L=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//     -> out_text 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 212 cycles after accept.
//  T2 FIPS-197 App.B, each L in {1,2,4,8,16}: key 2b7e151628aed2a6abf7158809cf4f3c,
//     pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; latency matches table.
//  T3 Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_text stable, in_ready=0,
//     second in_valid ignored; release -> handshake, in_ready=1 next cycle, queued block accepted.
//  T4 Reset at cycle 30 of a block (L=1) -> next cycle out_valid=0, busy=0, in_ready=1; fresh T1 passes.
//  T5 AES_ROUND_TAP_EN, App.B vector: round_idx 1 state a49c7ff2689f352b6b5bea43026a5049,
//     round_idx 10 state 3925841d02dc09fbdc118597196a0b32; exactly 10 round_valid pulses.
//  T6 Back-to-back random blocks (1000, out_ready=1) vs software AES model -> all match, no lost blocks.

Source files
------------

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core; SubBytes and SubWord share SBOX_LANES S-box lanes.
// Optional round tap ports (round_valid/round_idx/round_state) are enabled by defining AES_ROUND_TAP_EN.
module aes128_iter_core #(
    parameter int SBOX_LANES = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         busy
`ifdef AES_ROUND_TAP_EN
    ,
    output logic         round_valid,
    output logic [3:0]   round_idx,
    output logic [127:0] round_state
`endif
);

    // state | meaning
    // IDLE  | waiting for a block, in_ready high
    // INIT  | initial AddRoundKey
    // SUB   | SubBytes, SBOX_LANES bytes per cycle
    // KEY   | SubWord(RotWord(w3)) on the shared lanes
    // MIX   | ShiftRows, MixColumns, AddRoundKey, key expansion
    // DONE  | ciphertext held until out_ready

    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
              SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
            $error("aes128_iter_core: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam int L        = SBOX_LANES;
    localparam int KL       = (L < 4) ? L : 4;
    localparam int SUB_CYC  = 16 / L;
    localparam int KEY_CYC  = 4 / KL;
    localparam logic [3:0] SUB_LOAD = 4'(SUB_CYC - 1);
    localparam logic [3:0] KEY_LOAD = 4'(KEY_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_SUB, S_KEY, S_MIX, S_DONE} state_t;

    state_t       fsm;
    logic [127:0] st;
    logic [127:0] rk;
    logic [31:0]  sw;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [3:0]   cnt;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, v;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        v    = gmul(x252, x2);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
               {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    logic [7:0]   lane_in  [L];
    logic [7:0]   lane_out [L];
    logic [127:0] sub_next;
    logic [31:0]  key_next;
    logic [31:0]  rot_w3;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic [127:0] rk_next;
    logic [127:0] sr;
    logic [127:0] mix_result;

    // In KEY the first KL lanes are borrowed for SubWord; otherwise every lane serves st.
    for (genvar j = 0; j < L; j++) begin : g_lane
        if (j < KL) begin : g_shared
            assign lane_in[j] = (fsm == S_KEY) ? sw[31-8*j -: 8] : st[127-8*j -: 8];
        end else begin : g_state_only
            assign lane_in[j] = st[127-8*j -: 8];
        end
        assign lane_out[j] = sbox(lane_in[j]);
    end

    // Rotating by L bytes per cycle returns st to its original byte order after 16/L cycles.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        if (i < 16 - L) begin : g_shift
            assign sub_next[127-8*i -: 8] = st[127-8*(i+L) -: 8];
        end else begin : g_fill
            assign sub_next[127-8*i -: 8] = lane_out[i-(16-L)];
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_key
        if (i < 4 - KL) begin : g_shift
            assign key_next[31-8*i -: 8] = sw[31-8*(i+KL) -: 8];
        end else begin : g_fill
            assign key_next[31-8*i -: 8] = lane_out[i-(4-KL)];
        end
    end

    assign rot_w3     = {rk[23:0], rk[31:24]};
    assign w0n        = rk[127:96] ^ sw ^ {rcon, 24'h000000};
    assign w1n        = rk[95:64] ^ w0n;
    assign w2n        = rk[63:32] ^ w1n;
    assign w3n        = rk[31:0] ^ w2n;
    assign rk_next    = {w0n, w1n, w2n, w3n};
    assign sr         = shift_rows(st);
    assign mix_result = ((round == 4'd10) ? sr : mix_columns(sr)) ^ rk_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm       <= S_IDLE;
            st        <= '0;
            rk        <= '0;
            sw        <= '0;
            round     <= 4'd0;
            rcon      <= 8'h01;
            cnt       <= 4'd0;
            out_text  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= in_text;
                        rk       <= in_key;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= S_INIT;
                    end
                end
                S_INIT: begin
                    st    <= st ^ rk;
                    round <= 4'd1;
                    rcon  <= 8'h01;
                    cnt   <= SUB_LOAD;
                    fsm   <= S_SUB;
                end
                S_SUB: begin
                    st <= sub_next;
                    sw <= rot_w3;
                    if (cnt == 4'd0) begin
                        cnt <= KEY_LOAD;
                        fsm <= S_KEY;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_KEY: begin
                    sw <= key_next;
                    if (cnt == 4'd0) begin
                        fsm <= S_MIX;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_MIX: begin
                    st    <= mix_result;
                    rk    <= rk_next;
                    rcon  <= xtime(rcon);
                    round <= round + 4'd1;
                    if (round == 4'd10) begin
                        out_text  <= mix_result;
                        out_valid <= 1'b1;
                        fsm       <= S_DONE;
                    end else begin
                        cnt <= SUB_LOAD;
                        fsm <= S_SUB;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= S_IDLE;
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AES_ROUND_TAP_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            round_valid <= 1'b0;
            round_idx   <= 4'd0;
            round_state <= '0;
        end else begin
            round_valid <= (fsm == S_MIX);
            if (fsm == S_MIX) begin
                round_idx   <= round;
                round_state <= mix_result;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed bench for aes128_iter_core: one instance per legal SBOX_LANES value (1,2,4,8,16).
// Round-tap checks are compiled only when AES_ROUND_TAP_EN is defined.
module tb_aes128_iter_core;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         in_valid_a  [5];
    logic         in_ready_a  [5];
    logic         out_valid_a [5];
    logic         out_ready_a [5];
    logic [127:0] out_text_a  [5];
    logic         busy_a      [5];
`ifdef AES_ROUND_TAP_EN
    logic         rv_a [5];
    logic [3:0]   ri_a [5];
    logic [127:0] rs_a [5];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        aes128_iter_core #(.SBOX_LANES(1 << g)) u_dut (
            .clock    (clock),
            .reset    (reset),
            .in_valid (in_valid_a[g]),
            .in_ready (in_ready_a[g]),
            .in_text  (in_text),
            .in_key   (in_key),
            .out_valid(out_valid_a[g]),
            .out_ready(out_ready_a[g]),
            .out_text (out_text_a[g]),
            .busy     (busy_a[g])
`ifdef AES_ROUND_TAP_EN
            ,
            .round_valid(rv_a[g]),
            .round_idx  (ri_a[g]),
            .round_state(rs_a[g])
`endif
        );
    end

    // Offers one block, returns ciphertext and cycles from the accept cycle to out_valid.
    task automatic run_block(input int idx, input logic [127:0] key, input logic [127:0] pt,
                             output logic [127:0] ct, output int lat, output bit tmo);
        int guard;
        tmo = 1'b0;
        ct  = '0;
        lat = 0;
        @(negedge clock);
        in_key          = key;
        in_text         = pt;
        in_valid_a[idx] = 1'b1;
        guard = 0;
        while (in_ready_a[idx] !== 1'b1 && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 1000) begin
            tmo             = 1'b1;
            in_valid_a[idx] = 1'b0;
            return;
        end
        do begin
            @(negedge clock);
            in_valid_a[idx] = 1'b0;
            lat++;
        end while (out_valid_a[idx] !== 1'b1 && lat < 1000);
        if (out_valid_a[idx] !== 1'b1) tmo = 1'b1;
        ct = out_text_a[idx];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (out_valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a[0]); end
        n_cmp++;
        if (busy_a[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a[0]); end
        n_cmp++;
        if (out_text_a[0] !== 128'h0) begin n_bad++; $display("FAIL reset_out_text: got %h want 0", out_text_a[0]); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (in_ready_a[i] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready_a[i]); end
        end
    endtask

    task automatic test_fips_c1();
        logic [127:0] ct;
        int lat;
        bit tmo;
        run_block(0, KEY_C1, PT_C1, ct, lat, tmo);
        n_cmp++;
        if (tmo !== 1'b0) begin n_bad++; $display("FAIL c1_timeout: got timeout want completion"); end
        n_cmp++;
        if (ct !== CT_C1) begin n_bad++; $display("FAIL c1_text: got %h want %h", ct, CT_C1); end
        n_cmp++;
        if (lat !== 212) begin n_bad++; $display("FAIL c1_latency: got %0d want 212", lat); end
    endtask

    task automatic test_lanes();
        int exp_lat [5] = '{212, 112, 62, 42, 32};
        logic [127:0] ct;
        int lat;
        bit tmo;
        for (int i = 0; i < 5; i++) begin
            run_block(i, KEY_B, PT_B, ct, lat, tmo);
            n_cmp++;
            if (tmo !== 1'b0) begin n_bad++; $display("FAIL lanes_timeout[%0d]: got timeout want completion", i); end
            n_cmp++;
            if (ct !== CT_B) begin n_bad++; $display("FAIL lanes_text[%0d]: got %h want %h", i, ct, CT_B); end
            n_cmp++;
            if (lat !== exp_lat[i]) begin n_bad++; $display("FAIL lanes_latency[%0d]: got %0d want %0d", i, lat, exp_lat[i]); end
        end
    endtask

    task automatic test_zero_vector();
        logic [127:0] ct;
        int lat;
        bit tmo;
        run_block(2, 128'h0, 128'h0, ct, lat, tmo);
        n_cmp++;
        if (ct !== CT_Z) begin n_bad++; $display("FAIL zero_text: got %h want %h", ct, CT_Z); end
        n_cmp++;
        if (lat !== 62) begin n_bad++; $display("FAIL zero_latency: got %0d want 62", lat); end
    endtask

    task automatic test_backpressure();
        logic [127:0] ct;
        int lat;
        bit tmo;
        out_ready_a[0] = 1'b0;
        run_block(0, KEY_B, PT_B, ct, lat, tmo);
        n_cmp++;
        if (ct !== CT_B) begin n_bad++; $display("FAIL bp_first_text: got %h want %h", ct, CT_B); end
        in_key        = KEY_C1;
        in_text       = PT_C1;
        in_valid_a[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            n_cmp++;
            if (out_valid_a[0] !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, out_valid_a[0]); end
            n_cmp++;
            if (out_text_a[0] !== CT_B) begin n_bad++; $display("FAIL bp_hold_text c%0d: got %h want %h", c, out_text_a[0], CT_B); end
            n_cmp++;
            if (in_ready_a[0] !== 1'b0) begin n_bad++; $display("FAIL bp_hold_in_ready c%0d: got %b want 0", c, in_ready_a[0]); end
        end
        out_ready_a[0] = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (out_valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid_a[0]); end
        n_cmp++;
        if (in_ready_a[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready_a[0]); end
        n_cmp++;
        if (out_text_a[0] !== CT_B) begin n_bad++; $display("FAIL bp_keep_text: got %h want %h", out_text_a[0], CT_B); end
        lat = 0;
        do begin
            @(negedge clock);
            in_valid_a[0] = 1'b0;
            lat++;
        end while (out_valid_a[0] !== 1'b1 && lat < 1000);
        n_cmp++;
        if (out_text_a[0] !== CT_C1) begin n_bad++; $display("FAIL bp_queued_text: got %h want %h", out_text_a[0], CT_C1); end
        n_cmp++;
        if (lat !== 212) begin n_bad++; $display("FAIL bp_queued_latency: got %0d want 212", lat); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct;
        int lat;
        bit tmo;
        int seen;
        @(negedge clock);
        in_key        = KEY_C1;
        in_text       = PT_C1;
        in_valid_a[0] = 1'b1;
        @(negedge clock);
        in_valid_a[0] = 1'b0;
        repeat (29) @(negedge clock);
        n_cmp++;
        if (busy_a[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %b want 1", busy_a[0]); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_cmp++;
        if (out_valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b want 0", out_valid_a[0]); end
        n_cmp++;
        if (busy_a[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy_a[0]); end
        n_cmp++;
        if (in_ready_a[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready_a[0]); end
        n_cmp++;
        if (out_text_a[0] !== 128'h0) begin n_bad++; $display("FAIL rmid_out_text: got %h want 0", out_text_a[0]); end
        seen = 0;
        for (int c = 0; c < 220; c++) begin
            @(negedge clock);
            if (out_valid_a[0] === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL rmid_no_output: got %0d valid cycles want 0", seen); end
        run_block(0, KEY_C1, PT_C1, ct, lat, tmo);
        n_cmp++;
        if (ct !== CT_C1) begin n_bad++; $display("FAIL rmid_fresh_text: got %h want %h", ct, CT_C1); end
        n_cmp++;
        if (lat !== 212) begin n_bad++; $display("FAIL rmid_fresh_latency: got %0d want 212", lat); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] keys [3] = '{KEY_C1, KEY_B, 128'h0};
        logic [127:0] pts  [3] = '{PT_C1, PT_B, 128'h0};
        logic [127:0] exps [3] = '{CT_C1, CT_B, CT_Z};
        int out_cyc [3] = '{0, 0, 0};
        int ai, oi, cyc;
        bit acc;
        @(negedge clock);
        in_key        = keys[0];
        in_text       = pts[0];
        in_valid_a[1] = 1'b1;
        ai  = 0;
        oi  = 0;
        cyc = 0;
        while (oi < 3 && cyc < 2000) begin
            if (out_valid_a[1] === 1'b1) begin
                n_cmp++;
                if (out_text_a[1] !== exps[oi]) begin n_bad++; $display("FAIL b2b_text[%0d]: got %h want %h", oi, out_text_a[1], exps[oi]); end
                out_cyc[oi] = cyc;
                oi++;
            end
            acc = (in_valid_a[1] === 1'b1) && (in_ready_a[1] === 1'b1);
            @(negedge clock);
            cyc++;
            if (acc) begin
                ai++;
                if (ai < 3) begin
                    in_key  = keys[ai];
                    in_text = pts[ai];
                end else begin
                    in_valid_a[1] = 1'b0;
                end
            end
        end
        in_valid_a[1] = 1'b0;
        n_cmp++;
        if (oi !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d blocks want 3", oi); end
        n_cmp++;
        if (out_cyc[0] !== 112) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 112", out_cyc[0]); end
        n_cmp++;
        if (out_cyc[1] - out_cyc[0] !== 113) begin n_bad++; $display("FAIL b2b_period1: got %0d want 113", out_cyc[1] - out_cyc[0]); end
        n_cmp++;
        if (out_cyc[2] - out_cyc[1] !== 113) begin n_bad++; $display("FAIL b2b_period2: got %0d want 113", out_cyc[2] - out_cyc[1]); end
    endtask

`ifdef AES_ROUND_TAP_EN
    task automatic test_round_tap();
        logic [127:0] s1  = '0;
        logic [127:0] s10 = '0;
        int pulses = 0;
        int cyc = 0;
        @(negedge clock);
        in_key        = KEY_B;
        in_text       = PT_B;
        in_valid_a[3] = 1'b1;
        while (in_ready_a[3] !== 1'b1 && cyc < 1000) begin
            @(negedge clock);
            cyc++;
        end
        cyc = 0;
        do begin
            @(negedge clock);
            in_valid_a[3] = 1'b0;
            cyc++;
            if (rv_a[3] === 1'b1) begin
                pulses++;
                if (ri_a[3] == 4'd1) s1 = rs_a[3];
                if (ri_a[3] == 4'd10) s10 = rs_a[3];
            end
        end while (out_valid_a[3] !== 1'b1 && cyc < 1000);
        repeat (5) begin
            @(negedge clock);
            if (rv_a[3] === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 10) begin n_bad++; $display("FAIL tap_pulses: got %0d want 10", pulses); end
        n_cmp++;
        if (s1 !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin n_bad++; $display("FAIL tap_round1: got %h want a49c7ff2689f352b6b5bea43026a5049", s1); end
        n_cmp++;
        if (s10 !== CT_B) begin n_bad++; $display("FAIL tap_round10: got %h want %h", s10, CT_B); end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        in_text = '0;
        in_key  = '0;
        for (int i = 0; i < 5; i++) begin
            in_valid_a[i]  = 1'b0;
            out_ready_a[i] = 1'b1;
        end
        test_reset();
        test_fips_c1();
        test_lanes();
        test_zero_vector();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef AES_ROUND_TAP_EN
        test_round_tap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
